// File: rtl/tile_game.sv
// rtl/tile_game.sv - memory tile-matching game core
// Ten hidden tiles in five colour pairs, selected two at a time by PS/2 make codes.
module tile_game #(
  parameter int REVEAL_CYCLES = 16
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] ps2_key_data,
  input  logic       ps2_key_pressed,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic [3:0] gameModeState,
  output logic [2:0] inGameState
);

  typedef enum logic [1:0] {M_TITLE = 2'd0, M_PLAY = 2'd1, M_WIN = 2'd2} mode_e;
  typedef enum logic [1:0] {S_SEL1 = 2'd0, S_SEL2 = 2'd1, S_CHECK = 2'd2, S_SHOW = 2'd3} play_e;

  localparam int CW = $clog2(REVEAL_CYCLES + 1);
  localparam logic [3:0] NO_TILE = 4'hF;

  mode_e         mode_q, mode_d;
  play_e         play_q, play_d;
  logic [9:0]    matched_q, matched_d;
  logic [3:0]    sel1_q, sel1_d, sel2_q, sel2_d;
  logic [2:0]    pairs_q, pairs_d;
  logic [6:0]    attempts_q, attempts_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_q;

  logic       accept, key_is_tile, key_enter, key_matched;
  logic [3:0] key_tile;
  logic       show1, show2;

  function automatic logic [2:0] colour(input logic [3:0] t);
    case (t)
      4'd0, 4'd7: colour = 3'd1;
      4'd1, 4'd4: colour = 3'd2;
      4'd2, 4'd6: colour = 3'd3;
      4'd3, 4'd5: colour = 3'd4;
      4'd8, 4'd9: colour = 3'd5;
      default:    colour = 3'd0;
    endcase
  endfunction

  // One-hot of a tile index; NO_TILE shifts out to zero.
  function automatic logic [9:0] onehot(input logic [3:0] t);
    onehot = 10'b1 << t;
  endfunction

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'h40;
      4'd1: seg = 7'h79;
      4'd2: seg = 7'h24;
      4'd3: seg = 7'h30;
      4'd4: seg = 7'h19;
      4'd5: seg = 7'h12;
      4'd6: seg = 7'h02;
      4'd7: seg = 7'h78;
      4'd8: seg = 7'h00;
      4'd9: seg = 7'h10;
      default: seg = 7'h7F;
    endcase
  endfunction

  always_comb begin
    key_tile    = NO_TILE;
    key_is_tile = 1'b1;
    case (ps2_key_data)
      8'h16: key_tile = 4'd0;
      8'h1E: key_tile = 4'd1;
      8'h26: key_tile = 4'd2;
      8'h25: key_tile = 4'd3;
      8'h15: key_tile = 4'd4;
      8'h1D: key_tile = 4'd5;
      8'h24: key_tile = 4'd6;
      8'h2D: key_tile = 4'd7;
      8'h1C: key_tile = 4'd8;
      8'h1B: key_tile = 4'd9;
      default: key_is_tile = 1'b0;
    endcase
  end

  assign accept      = ps2_key_pressed & ~key_q;
  assign key_enter   = (ps2_key_data == 8'h5A);
  assign key_matched = |(matched_q & onehot(key_tile));

  always_comb begin
    mode_d     = mode_q;
    play_d     = play_q;
    matched_d  = matched_q;
    sel1_d     = sel1_q;
    sel2_d     = sel2_q;
    pairs_d    = pairs_q;
    attempts_d = attempts_q;
    cnt_d      = cnt_q;
    case (mode_q)
      M_PLAY: begin
        case (play_q)
          S_SEL1: if (accept && key_is_tile && !key_matched) begin
            sel1_d = key_tile;
            play_d = S_SEL2;
          end
          S_SEL2: if (accept && key_is_tile && !key_matched && key_tile != sel1_q) begin
            sel2_d     = key_tile;
            attempts_d = (attempts_q == 7'd99) ? attempts_q : attempts_q + 7'd1;
            play_d     = S_CHECK;
          end
          S_CHECK: if (colour(sel1_q) == colour(sel2_q)) begin
            matched_d = matched_q | onehot(sel1_q) | onehot(sel2_q);
            pairs_d   = pairs_q + 3'd1;
            sel1_d    = NO_TILE;
            sel2_d    = NO_TILE;
            play_d    = S_SEL1;
            if (pairs_q == 3'd4) mode_d = M_WIN;
          end else begin
            cnt_d  = CW'(REVEAL_CYCLES);
            play_d = S_SHOW;
          end
          default: if (cnt_q <= CW'(1)) begin
            cnt_d  = '0;
            sel1_d = NO_TILE;
            sel2_d = NO_TILE;
            play_d = S_SEL1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        endcase
      end
      default: if (accept && key_enter) begin
        mode_d     = M_PLAY;
        play_d     = S_SEL1;
        matched_d  = '0;
        pairs_d    = '0;
        attempts_d = '0;
        sel1_d     = NO_TILE;
        sel2_d     = NO_TILE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      mode_q     <= M_TITLE;
      play_q     <= S_SEL1;
      matched_q  <= '0;
      sel1_q     <= NO_TILE;
      sel2_q     <= NO_TILE;
      pairs_q    <= '0;
      attempts_q <= '0;
      cnt_q      <= '0;
      key_q      <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      play_q     <= play_d;
      matched_q  <= matched_d;
      sel1_q     <= sel1_d;
      sel2_q     <= sel2_d;
      pairs_q    <= pairs_d;
      attempts_q <= attempts_d;
      cnt_q      <= cnt_d;
      key_q      <= ps2_key_pressed;
    end
  end

  assign show1 = (mode_q == M_PLAY) && (play_q != S_SEL1);
  assign show2 = (mode_q == M_PLAY) && (play_q == S_CHECK || play_q == S_SHOW);

  assign gameModeState = {2'b00, mode_q};
  assign inGameState   = (mode_q == M_PLAY) ? {1'b0, play_q} : 3'd0;
  assign LEDR = (mode_q == M_WIN) ? 10'h3FF :
                matched_q | (show1 ? onehot(sel1_q) : 10'h0) | (show2 ? onehot(sel2_q) : 10'h0);

  assign HEX0 = seg(4'(attempts_q % 7'd10));
  assign HEX1 = seg(4'(attempts_q / 7'd10));
  assign HEX2 = seg({1'b0, pairs_q});
  assign HEX3 = show1 ? seg({1'b0, colour(sel1_q)}) : 7'h7F;
  assign HEX4 = show2 ? seg({1'b0, colour(sel2_q)}) : 7'h7F;
  assign HEX5 = seg({2'b00, mode_q});

endmodule

// File: tb/tb_tile_game.sv
// tb/tb_tile_game.sv - scoreboard bench for tile_game
// Reference model tracks game rules; expected snapshots are queued and checked at negedge.
module tb_tile_game;

  localparam int R = 16;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic [7:0] ps2_key_data;
  logic       ps2_key_pressed;
  logic [9:0] LEDR;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [3:0] gameModeState;
  logic [2:0] inGameState;

  tile_game #(.REVEAL_CYCLES(R)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .ps2_key_data(ps2_key_data),
    .ps2_key_pressed(ps2_key_pressed), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5),
    .gameModeState(gameModeState), .inGameState(inGameState)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         id;
    logic [3:0] mode;
    logic [2:0] ing;
    logic [9:0] led;
    logic [6:0] h0, h1, h2, h3, h4, h5;
  } snap_t;

  snap_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int step = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int         colour_tab [10] = '{1, 2, 3, 4, 2, 4, 3, 1, 5, 5};
  logic [7:0] key_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h1C, 8'h1B};

  int         m_mode, m_phase, m_sel1, m_sel2, m_pairs, m_att;
  logic [9:0] m_matched;

  function automatic int tile_of(input logic [7:0] code);
    tile_of = -1;
    for (int i = 0; i < 10; i++) if (key_codes[i] == code) tile_of = i;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_sel1 = -1; m_sel2 = -1;
    m_pairs = 0; m_att = 0; m_matched = '0;
  endtask

  task automatic model_key(input logic [7:0] code, output bit chk);
    int t;
    t = tile_of(code);
    chk = 1'b0;
    if (m_mode != 1) begin
      if (code == 8'h5A) begin
        m_mode = 1; m_phase = 0; m_sel1 = -1; m_sel2 = -1;
        m_pairs = 0; m_att = 0; m_matched = '0;
      end
    end else if (m_phase == 0 && t >= 0 && !m_matched[t]) begin
      m_sel1 = t; m_phase = 1;
    end else if (m_phase == 1 && t >= 0 && !m_matched[t] && t != m_sel1) begin
      m_sel2 = t; m_phase = 2; chk = 1'b1;
      m_att = (m_att < 99) ? m_att + 1 : 99;
    end
  endtask

  task automatic model_resolve(output bit mism);
    if (colour_tab[m_sel1] == colour_tab[m_sel2]) begin
      m_matched[m_sel1] = 1'b1;
      m_matched[m_sel2] = 1'b1;
      m_pairs++;
      m_phase = 0; m_sel1 = -1; m_sel2 = -1;
      if (m_pairs == 5) m_mode = 2;
      mism = 1'b0;
    end else begin
      m_phase = 3;
      mism = 1'b1;
    end
  endtask

  task automatic push_exp();
    snap_t s;
    s.id   = step++;
    s.mode = 4'(m_mode);
    s.ing  = (m_mode == 1) ? 3'(m_phase) : 3'd0;
    s.led  = m_matched;
    if (m_mode == 1 && m_phase >= 1) s.led[m_sel1] = 1'b1;
    if (m_mode == 1 && m_phase >= 2) s.led[m_sel2] = 1'b1;
    if (m_mode == 2) s.led = 10'h3FF;
    s.h0 = seg_tab[m_att % 10];
    s.h1 = seg_tab[m_att / 10];
    s.h2 = seg_tab[m_pairs];
    s.h3 = (m_mode == 1 && m_phase >= 1) ? seg_tab[colour_tab[m_sel1]] : 7'h7F;
    s.h4 = (m_mode == 1 && m_phase >= 2) ? seg_tab[colour_tab[m_sel2]] : 7'h7F;
    s.h5 = seg_tab[m_mode];
    exp_q.push_back(s);
  endtask

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  initial begin
    snap_t e;
    forever begin
      @(negedge CLOCK_50);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("gameModeState", e.id, 32'(gameModeState), 32'(e.mode));
        cmp("inGameState", e.id, 32'(inGameState), 32'(e.ing));
        cmp("LEDR", e.id, 32'(LEDR), 32'(e.led));
        cmp("HEX0", e.id, 32'(HEX0), 32'(e.h0));
        cmp("HEX1", e.id, 32'(HEX1), 32'(e.h1));
        cmp("HEX2", e.id, 32'(HEX2), 32'(e.h2));
        cmp("HEX3", e.id, 32'(HEX3), 32'(e.h3));
        cmp("HEX4", e.id, 32'(HEX4), 32'(e.h4));
        cmp("HEX5", e.id, 32'(HEX5), 32'(e.h5));
      end
    end
  end

  // Drives one key, then follows CHECK and the full SHOW window when a second selection lands.
  task automatic press(input logic [7:0] code, input int hold);
    bit chk, mism;
    ps2_key_data = code;
    ps2_key_pressed = 1'b1;
    @(posedge CLOCK_50); #1;
    model_key(code, chk);
    push_exp();
    if (chk) begin
      ps2_key_pressed = 1'b0;
      @(posedge CLOCK_50); #1;
      model_resolve(mism);
      push_exp();
      if (mism) begin
        repeat (R - 1) @(posedge CLOCK_50);
        #1 push_exp();
        @(posedge CLOCK_50); #1;
        m_phase = 0; m_sel1 = -1; m_sel2 = -1;
        push_exp();
      end
    end else begin
      repeat (hold - 1) begin
        @(posedge CLOCK_50); #1;
        push_exp();
      end
      ps2_key_pressed = 1'b0;
      @(posedge CLOCK_50); #1;
      push_exp();
    end
  endtask

  initial begin
    bit chk, mism;
    int r;
    logic [7:0] code;
    reset = 1'b1;
    ps2_key_data = 8'h00;
    ps2_key_pressed = 1'b0;
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1 push_exp();
    reset = 1'b0;
    @(posedge CLOCK_50); #1 push_exp();

    press(8'h16, 1);
    press(8'h5A, 1);
    press(8'h16, 1); press(8'h1E, 1);
    press(8'h16, 1); press(8'h2D, 1);
    press(8'h1E, 1); press(8'h15, 1);
    press(8'h16, 1);
    press(8'h26, 7);
    press(8'h26, 1);
    press(8'h5A, 1);
    press(8'h25, 1);
    press(8'h26, 1); press(8'h24, 1);
    press(8'h25, 1); press(8'h1D, 1);
    press(8'h1C, 1); press(8'h1B, 1);
    press(8'h16, 1);

    press(8'h5A, 1);
    press(8'h16, 1);
    ps2_key_data = 8'h1E;
    ps2_key_pressed = 1'b1;
    @(posedge CLOCK_50); #1;
    model_key(8'h1E, chk);
    push_exp();
    ps2_key_pressed = 1'b0;
    @(posedge CLOCK_50); #1;
    model_resolve(mism);
    push_exp();
    ps2_key_data = 8'h26;
    ps2_key_pressed = 1'b1;
    @(posedge CLOCK_50); #1 push_exp();
    ps2_key_pressed = 1'b0;
    @(posedge CLOCK_50); #1;
    reset = 1'b1;
    #1;
    model_reset();
    push_exp();
    repeat (2) @(posedge CLOCK_50);
    #1 push_exp();
    reset = 1'b0;
    press(8'h5A, 7);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7) code = key_codes[$urandom_range(0, 9)];
      else if (r < 8) code = 8'h5A;
      else code = 8'($urandom);
      press(code, $urandom_range(1, 4));
    end

    repeat (3) @(posedge CLOCK_50);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
